// File: rtl/wg_slot_id_release_pkg.sv
// Shared widths, types and helpers for per-CU workgroup slot tracking.
// Slot selection picks the lowest free index (bit 0 has highest priority).
package wg_slot_id_release_pkg;

  localparam int WG_ID_WIDTH      = 6;
  localparam int WG_SLOT_ID_WIDTH = 3;
  localparam int SLOT_ID_NUM      = 1 << WG_SLOT_ID_WIDTH;

  typedef logic [WG_ID_WIDTH-1:0]      wg_id_t;
  typedef logic [WG_SLOT_ID_WIDTH-1:0] slot_id_t;
  typedef logic [SLOT_ID_NUM-1:0]      slot_map_t;

  // Isolate the lowest set bit as a one-hot grant.
  function automatic slot_map_t fixed_pri(input slot_map_t req);
    return req & (~req + slot_map_t'(1));
  endfunction

  // One-hot to binary index.
  function automatic slot_id_t one2bin(input slot_map_t oh);
    slot_id_t idx;
    idx = '0;
    for (int i = 0; i < SLOT_ID_NUM; i++) begin
      if (oh[i]) idx = idx | slot_id_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wg_done_fifo.sv
// Two-entry valid/ready FIFO holding completion records.
// Output always comes from the storage register; there is no bypass.
module wg_done_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/wg_slot_id_release.sv
// Per-CU slot allocator with wg_id table and release path.
// Retired workgroups are reported through a 2-entry done queue.
module wg_slot_id_release
  import wg_slot_id_release_pkg::*;
#(
  parameter int NUMBER_CU   = 2,
  parameter int CU_ID_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  input  logic [WG_ID_WIDTH-1:0]      alloc_wg_id_i,
  input  logic [CU_ID_WIDTH-1:0]      alloc_cu_id_i,
  output logic                        alloc_resp_valid_o,
  output logic [WG_SLOT_ID_WIDTH-1:0] alloc_slot_id_o,
  input  logic                        rel_valid_i,
  output logic                        rel_ready_o,
  input  logic [CU_ID_WIDTH-1:0]      rel_cu_id_i,
  input  logic [WG_SLOT_ID_WIDTH-1:0] rel_slot_id_i,
  output logic                        done_valid_o,
  input  logic                        done_ready_i,
  output logic [WG_ID_WIDTH-1:0]      done_wg_id_o,
  output logic [CU_ID_WIDTH-1:0]      done_cu_id_o,
  output logic [NUMBER_CU-1:0]        cu_full_o,
  output logic                        all_idle_o,
  output logic                        err_free_o
);

  localparam int QW = WG_ID_WIDTH + CU_ID_WIDTH;

  slot_map_t [NUMBER_CU-1:0] occ;
  slot_map_t [NUMBER_CU-1:0] occ_nxt;
  wg_id_t    tbl [NUMBER_CU][SLOT_ID_NUM];

  logic      alloc_cu_ok;
  logic      rel_cu_ok;
  slot_map_t free_map;
  slot_id_t  free_slot;
  logic      alloc_acc;
  logic      rel_acc;
  logic      rel_hit;
  logic      q_ready;
  logic      q_valid;
  logic [QW-1:0] q_din;
  logic [QW-1:0] q_dout;

  assign alloc_cu_ok = int'(alloc_cu_id_i) < NUMBER_CU;
  assign rel_cu_ok   = int'(rel_cu_id_i) < NUMBER_CU;

  assign free_map  = alloc_cu_ok ? ~occ[alloc_cu_id_i] : '0;
  assign free_slot = one2bin(fixed_pri(free_map));

  assign alloc_ready_o = alloc_cu_ok & (|free_map);
  assign alloc_acc     = alloc_valid_i & alloc_ready_o;

  assign rel_ready_o = q_ready;
  assign rel_acc     = rel_valid_i & rel_ready_o;
  assign rel_hit     = rel_acc & rel_cu_ok &
                       occ[rel_cu_id_i][rel_slot_id_i];

  assign q_din = {tbl[rel_cu_id_i][rel_slot_id_i], rel_cu_id_i};

  // Alloc sets and release clears distinct bits of the bitmap.
  always_comb begin
    occ_nxt = occ;
    if (alloc_acc) occ_nxt[alloc_cu_id_i][free_slot] = 1'b1;
    if (rel_hit)   occ_nxt[rel_cu_id_i][rel_slot_id_i] = 1'b0;
  end

  // Bitmap, slot table, response pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ                <= '0;
      alloc_resp_valid_o <= 1'b0;
      alloc_slot_id_o    <= '0;
      err_free_o         <= 1'b0;
      for (int c = 0; c < NUMBER_CU; c++) begin
        for (int s = 0; s < SLOT_ID_NUM; s++) begin
          tbl[c][s] <= '0;
        end
      end
    end else begin
      occ                <= occ_nxt;
      alloc_resp_valid_o <= alloc_acc;
      if (alloc_acc) begin
        alloc_slot_id_o               <= free_slot;
        tbl[alloc_cu_id_i][free_slot] <= alloc_wg_id_i;
      end
      if (rel_acc & ~rel_hit) err_free_o <= 1'b1;
    end
  end

  wg_done_fifo #(
    .W (QW)
  ) u_done_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rel_hit),
    .in_ready  (q_ready),
    .in_data   (q_din),
    .out_valid (q_valid),
    .out_ready (done_ready_i),
    .out_data  (q_dout)
  );

  assign done_valid_o = q_valid;
  assign done_wg_id_o = q_dout[QW-1:CU_ID_WIDTH];
  assign done_cu_id_o = q_dout[CU_ID_WIDTH-1:0];

  // Per-CU full flags from the registered bitmap.
  always_comb begin
    cu_full_o = '0;
    for (int c = 0; c < NUMBER_CU; c++) begin
      cu_full_o[c] = &occ[c];
    end
  end

  assign all_idle_o = ~(|occ) & ~q_valid;

endmodule

// File: doc/wg_slot_id_release.md
Name: wg_slot_id_release

Overview:
- Reverse path of per-CU workgroup slot management: allocates the lowest free slot per CU for a dispatched wg_id and records the wg_id in a slot table.
- When a CU retires a workgroup by (cu_id, slot_id), looks up the owning wg_id, frees the slot and forwards a completion record to the dispatcher through a 2-entry output queue.
- Sits between the CTA allocator/dispatcher and the CU completion interface.

Parameters:
- NUMBER_CU, 2, number of compute units tracked.
- CU_ID_WIDTH, 1, width of CU id fields; 2**CU_ID_WIDTH >= NUMBER_CU.
- SLOT_ID_NUM (localparam), 1<<`WG_SLOT_ID_WIDTH, slots per CU.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid_i  in  1  allocation request.
- alloc_ready_o  out  1  request accepted this cycle (valid&ready).
- alloc_wg_id_i  in  `WG_ID_WIDTH  workgroup to place.
- alloc_cu_id_i  in  CU_ID_WIDTH  target CU.
- alloc_resp_valid_o  out  1  one-cycle pulse, slot assigned.
- alloc_slot_id_o  out  `WG_SLOT_ID_WIDTH  assigned slot.
- rel_valid_i  in  1  CU reports completion.
- rel_ready_o  out  1  completion accepted.
- rel_cu_id_i  in  CU_ID_WIDTH  retiring CU.
- rel_slot_id_i  in  `WG_SLOT_ID_WIDTH  retiring slot.
- done_valid_o  out  1  completion record available.
- done_ready_i  in  1  dispatcher consumes record.
- done_wg_id_o  out  `WG_ID_WIDTH  wg_id of retired workgroup.
- done_cu_id_o  out  CU_ID_WIDTH  its CU.
- cu_full_o  out  NUMBER_CU  bit c = all slots of CU c occupied.
- all_idle_o  out  1  no slot occupied and output queue empty.
- err_free_o  out  1  sticky: release of unoccupied slot or out-of-range CU.

Behaviour:
- Reset (async): bitmap, slot table, queue count 0.
  - alloc_resp_valid_o=0, alloc_slot_id_o=0, done_valid_o=0, done_wg_id_o=0, done_cu_id_o=0, err_free_o=0.
  - cu_full_o=0, all_idle_o=1.
  - Reset mid-operation discards every allocation and every queued record.
- Allocation:
  - alloc_ready_o = alloc_cu_id_i < NUMBER_CU and at least one free slot in that CU. Combinational from registered bitmap only.
  - On accept, the lowest-index free slot (fixed priority, bit 0 highest) is marked occupied and the table entry is written with alloc_wg_id_i.
  - Next cycle: alloc_resp_valid_o=1 for exactly one cycle, with alloc_slot_id_o = chosen slot. No backpressure on the response.
- Release:
  - rel_ready_o = queue count < 2; rel_valid_i is ignored otherwise.
  - On accept with a valid CU and an occupied slot: clear the bitmap bit and push {table wg_id, cu_id} into the queue.
  - On accept with an unoccupied slot or cu >= NUMBER_CU: no push, bitmap unchanged, err_free_o set until reset.
- Queue:
  - 2-entry FIFO; head drives done_*; pop when done_valid_o & done_ready_i.
  - Latency: release accepted at edge N into an empty queue gives done_valid_o=1 after edge N.
  - Push and pop in the same cycle with count 1 or 2 keeps the count. Data held stable while done_valid_o=1 and done_ready_i=0.
  - No bypass: the done record always comes from the register, even when the queue is empty.
- Simultaneous alloc and release:
  - Both take effect in the same cycle.
  - Allocation uses the pre-edge bitmap, so a slot freed this cycle is not reallocated until the next cycle, even on the same CU.
  - Both paths write distinct bitmap bits; the slot table is written only by allocation.
- cu_full_o and all_idle_o come combinationally from registered state.

Decomposition:
- `WG_ID_WIDTH and `WG_SLOT_ID_WIDTH come from define.v; no new shared constants.
- Reuse fixed_pri_arb and one2bin for lowest-free-slot selection.
- One natural sub-module: wg_done_fifo (2-entry valid/ready FIFO, width `WG_ID_WIDTH+CU_ID_WIDTH).

Test Plan:
- Bench config: NUMBER_CU=2, `WG_SLOT_ID_WIDTH=3 (8 slots).
- Reset, then alloc wg 5 to cu0, then wg 9 to cu0 -> alloc_slot_id_o=0 then 1, each one cycle after accept; all_idle_o falls to 0.
- Allocate 8 wgs to cu1 -> cu_full_o=2'b10, alloc_ready_o=0 for cu1; release cu1 slot 3 -> done_wg_id_o = wg in slot 3, done_cu_id_o=1; next alloc to cu1 returns slot 3.
- Same cycle: release cu0 slot 0 and alloc cu0 with slots 0..6 full -> alloc gets slot 7, not 0; the following alloc gets slot 0.
- Hold done_ready_i=0 and issue 3 releases -> rel_ready_o=0 after 2 accepts; head record stable. Then done_ready_i=1 drains in order with no loss.
- Release cu0 slot 4 while unoccupied -> no done_valid_o, err_free_o=1 and sticky. Assert rst_n low mid-queue -> all outputs return to reset values immediately.
